// File: rtl/apu_framectl.sv
`default_nettype none
// ============================================================================
//  Module   : apu_framectl
//  Purpose  : APU frame-counter register controller. Decodes $4017 writes and
//             $4015 reads, holds mode/IRQ-enable and sequences the delayed
//             timer reset (update) and IRQ-clear strobes (clrint).
//  Options  : APU_FRAMECTL_JITTER_EN - delay follows sampled apu_cycle (3/4).
//  Revision : 1.0 - initial release
// ============================================================================
module apu_framectl #(
    parameter logic [4:0] ADDR_FC = 5'h17,
    parameter logic [4:0] ADDR_ST = 5'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       apu_cycle,
    input  logic       frame_irq,
    output logic       mode,
    output logic       interrupt_en,
    output logic       update,
    output logic       clrint,
    output logic       st_frame_irq,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_FIRE  = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic       r_pend_mode;

    logic       w_wr_fc;
    logic       w_rd_st;
    logic [1:0] w_load;
    logic       w_unused;

    assign w_wr_fc = cpu_wr && (cpu_addr == ADDR_FC);
    // A simultaneous write wins the bus; the read side is dropped entirely.
    assign w_rd_st = cpu_rd && !cpu_wr && (cpu_addr == ADDR_ST);

`ifdef APU_FRAMECTL_JITTER_EN
    assign w_load = apu_cycle ? 2'd3 : 2'd2;
`else
    assign w_load = 2'd2;
`endif

    assign w_unused = ^{cpu_wdata[5:0], apu_cycle};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_pend_mode  <= 1'b0;
            mode         <= 1'b0;
            interrupt_en <= 1'b1;
            update       <= 1'b0;
            clrint       <= 1'b0;
            st_frame_irq <= 1'b0;
            busy         <= 1'b0;
        end else begin
            update <= 1'b0;
            clrint <= (w_wr_fc && cpu_wdata[6]) || w_rd_st;

            if (w_rd_st) begin
                st_frame_irq <= frame_irq;
            end

            if (w_wr_fc) begin
                // Any write restarts the delay; a pending write is discarded.
                r_pend_mode  <= cpu_wdata[7];
                interrupt_en <= ~cpu_wdata[6];
                r_cnt        <= w_load;
                r_state      <= S_DELAY;
                busy         <= 1'b1;
            end else begin
                case (r_state)
                    S_DELAY: begin
                        r_cnt <= r_cnt - 2'd1;
                        busy  <= 1'b1;
                        if (r_cnt == 2'd1) begin
                            r_state <= S_FIRE;
                            update  <= 1'b1;
                            mode    <= r_pend_mode;
                        end
                    end
                    S_FIRE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= 2'd0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apu_framectl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apu_framectl
//  Purpose  : Scoreboard bench for apu_framectl against a cycle-schedule model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apu_framectl;

    localparam logic [4:0] ADDR_FC = 5'h17;
    localparam logic [4:0] ADDR_ST = 5'h15;
`ifdef APU_FRAMECTL_JITTER_EN
    localparam bit JIT = 1'b1;
`else
    localparam bit JIT = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cpu_wr    = 1'b0;
    logic       cpu_rd    = 1'b0;
    logic [4:0] cpu_addr  = 5'd0;
    logic [7:0] cpu_wdata = 8'd0;
    logic       apu_cycle = 1'b0;
    logic       frame_irq = 1'b0;
    logic       mode, interrupt_en, update, clrint, st_frame_irq, busy;

    apu_framectl #(.ADDR_FC(ADDR_FC), .ADDR_ST(ADDR_ST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .apu_cycle    (apu_cycle),
        .frame_irq    (frame_irq),
        .mode         (mode),
        .interrupt_en (interrupt_en),
        .update       (update),
        .clrint       (clrint),
        .st_frame_irq (st_frame_irq),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] exp_q[$];

    // Model state: absolute cycle at which the pending update fires.
    int cyc    = 0;
    int sched  = -1;
    bit m_mode = 1'b0;
    bit m_ie   = 1'b1;
    bit m_st   = 1'b0;
    bit m_pend = 1'b0;

    string names[6] = '{"mode", "interrupt_en", "update", "clrint", "st_frame_irq", "busy"};

    // Inputs held during cycle 'cyc' -> expected outputs during cycle cyc+1.
    function automatic logic [5:0] model(input bit r, input bit w, input bit rd,
                                         input logic [4:0] a, input logic [7:0] d,
                                         input bit ac, input bit fi);
        bit wfc   = w && (a == ADDR_FC);
        bit rds   = rd && !w && (a == ADDR_ST);
        bit e_clr = 1'b0;
        bit e_upd = 1'b0;
        if (!r) begin
            m_mode = 1'b0;
            m_ie   = 1'b1;
            m_st   = 1'b0;
            sched  = -1;
        end else begin
            e_clr = (wfc && d[6]) || rds;
            if (rds) m_st = fi;
            if (wfc) begin
                m_ie   = !d[6];
                m_pend = d[7];
                sched  = cyc + ((JIT && ac) ? 4 : 3);
            end
            if (sched == cyc + 1) begin
                e_upd  = 1'b1;
                m_mode = m_pend;
            end
        end
        return {m_mode, m_ie, e_upd, e_clr, m_st, (sched >= cyc + 1)};
    endfunction

    task automatic drive(input bit r, input bit w, input bit rd, input logic [4:0] a,
                         input logic [7:0] d, input bit ac, input bit fi);
        @(posedge clk);
        #2;
        rst_n     = r;
        cpu_wr    = w;
        cpu_rd    = rd;
        cpu_addr  = a;
        cpu_wdata = d;
        apu_cycle = ac;
        frame_irq = fi;
        exp_q.push_back(model(r, w, rd, a, d, ac, fi));
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic wr_fc(input logic [7:0] d, input bit ac, input bit fi);
        drive(1'b1, 1'b1, 1'b0, ADDR_FC, d, ac, fi);
    endtask

    // Monitor: compares every cycle the DUT presents against the queued record.
    initial begin
        logic [5:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {mode, interrupt_en, update, clrint, st_frame_irq, busy};
                for (int i = 0; i < 6; i++) begin
                    n_checks++;
                    if (got[5-i] !== e[5-i]) begin
                        n_fail++;
                        $display("FAIL %s t=%0t got %b expected %b", names[i], $time, got[5-i], e[5-i]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got timeout expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         r, w, rd, ac, fi;
        int         s;
        logic [4:0] a;
        logic [7:0] d;

        repeat (3) drive(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        idle(10);

        wr_fc(8'h80, 1'b0, 1'b0); idle(6);
        wr_fc(8'h00, 1'b1, 1'b0); idle(6);
        wr_fc(8'h80, 1'b1, 1'b0); idle(6);
        wr_fc(8'h40, 1'b0, 1'b1); idle(6);
        wr_fc(8'h40, 1'b1, 1'b1); idle(6);
        wr_fc(8'h00, 1'b0, 1'b0); idle(6);

        // Superseded write: only the second one may produce update.
        wr_fc(8'h80, 1'b0, 1'b0); idle(1);
        wr_fc(8'h00, 1'b0, 1'b0); idle(6);

        drive(1'b1, 1'b0, 1'b1, ADDR_ST, 8'd0, 1'b0, 1'b1); idle(3);
        drive(1'b1, 1'b1, 1'b1, ADDR_ST, 8'hC0, 1'b0, 1'b0); idle(3);
        drive(1'b1, 1'b1, 1'b1, ADDR_FC, 8'h00, 1'b0, 1'b0); idle(6);

        wr_fc(8'hC0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        idle(6);

        // Write landing in the update cycle must not cancel that pulse.
        wr_fc(8'h80, 1'b0, 1'b0); idle(2);
        wr_fc(8'h00, 1'b0, 1'b0); idle(6);

        wr_fc(8'h40, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, ADDR_ST, 8'd0, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, 5'h14, 8'd0, 1'b0, 1'b1);
        idle(6);

        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 59) != 0);
            w  = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 5) == 0);
            s  = int'($urandom_range(0, 3));
            a  = (s < 2) ? ADDR_FC : ((s == 2) ? ADDR_ST : 5'($urandom_range(0, 31)));
            d  = 8'($urandom);
            ac = 1'($urandom_range(0, 1));
            fi = 1'($urandom_range(0, 1));
            drive(r, w, rd, a, d, ac, fi);
        end
        idle(8);

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
